// File: rtl/dram_l2_pkg.sv
// Shared widths and FSM encoding for the DRAM-to-L2 read-return path.
package dram_l2_pkg;

    localparam int CHUNK_W     = 128;
    localparam int CHUNK_ECC_W = 28;
    localparam int CHUNKS      = 4;
    localparam int LINE_W      = CHUNK_W * CHUNKS;
    localparam int LINE_ECC_W  = CHUNK_ECC_W * CHUNKS;
    localparam int REQ_ID_W    = 3;
    localparam int CHUNK_ID_W  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ASM  = 1'b1
    } asm_state_e;

    // Chunk index expected after `cnt` beats of a line that began at `start`.
    function automatic logic [CHUNK_ID_W-1:0] next_chunk(input logic [CHUNK_ID_W-1:0] start,
                                                         input logic [CHUNK_ID_W-1:0] cnt);
        return start + cnt;
    endfunction

endpackage

// File: rtl/dram_l2_rdret_dly.sv
// Registered delay pipe carrying the r0 strobe and its control fields down to r2.
module dram_l2_rdret_dly #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 5
) (
    input  logic             rclk,
    input  logic             rst_l,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] ctl_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] ctl_o
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] ctl_q [DEPTH];

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ctl_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_i;
            ctl_q[0] <= ctl_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                ctl_q[i] <= ctl_q[i-1];
            end
        end
    end

    assign vld_o = vld_q[DEPTH-1];
    assign ctl_o = ctl_q[DEPTH-1];

endmodule

// File: rtl/dram_l2_rdret_asm.sv
// Collects four r2 chunks (any wrap start) into one 512-bit line and hands it to
// the L2 fill path through a single-entry holding register.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | no partial line; next beat starts a line
//   ST_ASM  | 1..3 chunks collected; waiting for next wrap chunk or timeout
module dram_l2_rdret_asm
    import dram_l2_pkg::*;
#(
    parameter int TMO_CYC = 63
) (
    input  logic                    rclk,
    input  logic                    rst_l,
    input  logic                    dram_sctag_data_vld_r0,
    input  logic [CHUNK_ID_W-1:0]   dram_sctag_chunk_id_r0,
    input  logic [REQ_ID_W-1:0]     dram_sctag_rd_req_id_r0,
    input  logic [CHUNK_W-1:0]      dram_scbuf_data_r2,
    input  logic [CHUNK_ECC_W-1:0]  dram_scbuf_ecc_r2,
    input  logic                    dram_sctag_secc_err_r2,
    input  logic                    dram_sctag_mecc_err_r2,
    input  logic                    rdret_fill_rdy,
    output logic                    rdret_fill_vld,
    output logic [LINE_W-1:0]       rdret_fill_data,
    output logic [LINE_ECC_W-1:0]   rdret_fill_ecc,
    output logic [REQ_ID_W-1:0]     rdret_fill_req_id,
    output logic                    rdret_fill_secc,
    output logic                    rdret_fill_mecc,
    output logic                    rdret_seq_err,
    output logic                    rdret_ovfl_err,
    output logic                    rdret_tmo_err
);

    localparam int         CTL_W    = CHUNK_ID_W + REQ_ID_W;
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    logic                  beat;
    logic [CTL_W-1:0]      ctl_r2;
    logic [CHUNK_ID_W-1:0] chunk_r2;
    logic [REQ_ID_W-1:0]   id_r2;

    dram_l2_rdret_dly #(
        .DEPTH (2),
        .WIDTH (CTL_W)
    ) u_dly (
        .rclk  (rclk),
        .rst_l (rst_l),
        .vld_i (dram_sctag_data_vld_r0),
        .ctl_i ({dram_sctag_chunk_id_r0, dram_sctag_rd_req_id_r0}),
        .vld_o (beat),
        .ctl_o (ctl_r2)
    );

    assign chunk_r2 = ctl_r2[CTL_W-1:REQ_ID_W];
    assign id_r2    = ctl_r2[REQ_ID_W-1:0];

    asm_state_e            state_q;
    logic [CHUNK_ID_W-1:0] start_q;
    logic [CHUNK_ID_W-1:0] cnt_q;
    logic [REQ_ID_W-1:0]   id_q;
    logic                  secc_acc_q;
    logic                  mecc_acc_q;
    logic [7:0]            idle_q;
    logic                  seq_err_q;
    logic                  tmo_err_q;
    logic [LINE_W-1:0]     line_data_q;
    logic [LINE_ECC_W-1:0] line_ecc_q;

    logic                  hold_vld_q;
    logic [LINE_W-1:0]     hold_data_q;
    logic [LINE_ECC_W-1:0] hold_ecc_q;
    logic [REQ_ID_W-1:0]   hold_id_q;
    logic                  hold_secc_q;
    logic                  hold_mecc_q;
    logic                  ovfl_err_q;

    logic                  beat_match;
    logic                  line_done;
    logic                  timeout;
    logic [LINE_W-1:0]     line_data_d;
    logic [LINE_ECC_W-1:0] line_ecc_d;

    assign beat_match = (state_q == ST_ASM) && (id_r2 == id_q) &&
                        (chunk_r2 == next_chunk(start_q, cnt_q));
    assign line_done  = beat && beat_match && (cnt_q == 2'd3);
    assign timeout    = (state_q == ST_ASM) && !beat && (idle_q == TMO_LAST);

    always_comb begin
        line_data_d = line_data_q;
        line_ecc_d  = line_ecc_q;
        line_data_d[int'(chunk_r2)*CHUNK_W +: CHUNK_W]        = dram_scbuf_data_r2;
        line_ecc_d[int'(chunk_r2)*CHUNK_ECC_W +: CHUNK_ECC_W] = dram_scbuf_ecc_r2;
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            state_q    <= ST_IDLE;
            start_q    <= '0;
            cnt_q      <= '0;
            id_q       <= '0;
            secc_acc_q <= 1'b0;
            mecc_acc_q <= 1'b0;
            idle_q     <= '0;
            seq_err_q  <= 1'b0;
            tmo_err_q  <= 1'b0;
        end else begin
            seq_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    idle_q <= '0;
                    if (beat) begin
                        state_q    <= ST_ASM;
                        start_q    <= chunk_r2;
                        cnt_q      <= 2'd1;
                        id_q       <= id_r2;
                        secc_acc_q <= dram_sctag_secc_err_r2;
                        mecc_acc_q <= dram_sctag_mecc_err_r2;
                    end
                end
                ST_ASM: begin
                    if (beat) begin
                        idle_q <= '0;
                        if (!beat_match) begin
                            // Offending beat becomes the first chunk of a fresh line.
                            seq_err_q  <= 1'b1;
                            start_q    <= chunk_r2;
                            cnt_q      <= 2'd1;
                            id_q       <= id_r2;
                            secc_acc_q <= dram_sctag_secc_err_r2;
                            mecc_acc_q <= dram_sctag_mecc_err_r2;
                        end else if (cnt_q == 2'd3) begin
                            state_q    <= ST_IDLE;
                            cnt_q      <= '0;
                            secc_acc_q <= 1'b0;
                            mecc_acc_q <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_q + 2'd1;
                            secc_acc_q <= secc_acc_q | dram_sctag_secc_err_r2;
                            mecc_acc_q <= mecc_acc_q | dram_sctag_mecc_err_r2;
                        end
                    end else if (timeout) begin
                        tmo_err_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                        idle_q     <= '0;
                        cnt_q      <= '0;
                        secc_acc_q <= 1'b0;
                        mecc_acc_q <= 1'b0;
                    end else begin
                        idle_q <= idle_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            line_data_q <= '0;
            line_ecc_q  <= '0;
        end else if (beat) begin
            line_data_q <= line_data_d;
            line_ecc_q  <= line_ecc_d;
        end
    end

    // Loading while the held line drains this cycle keeps lines back-to-back.
    always_ff @(posedge rclk) begin
        if (!rst_l) begin
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            hold_ecc_q  <= '0;
            hold_id_q   <= '0;
            hold_secc_q <= 1'b0;
            hold_mecc_q <= 1'b0;
            ovfl_err_q  <= 1'b0;
        end else begin
            ovfl_err_q <= 1'b0;
            if (line_done) begin
                if (!hold_vld_q || rdret_fill_rdy) begin
                    hold_vld_q  <= 1'b1;
                    hold_data_q <= line_data_d;
                    hold_ecc_q  <= line_ecc_d;
                    hold_id_q   <= id_q;
                    hold_secc_q <= secc_acc_q | dram_sctag_secc_err_r2;
                    hold_mecc_q <= mecc_acc_q | dram_sctag_mecc_err_r2;
                end else begin
                    ovfl_err_q <= 1'b1;
                end
            end else if (hold_vld_q && rdret_fill_rdy) begin
                hold_vld_q <= 1'b0;
            end
        end
    end

    assign rdret_fill_vld    = hold_vld_q;
    assign rdret_fill_data   = hold_data_q;
    assign rdret_fill_ecc    = hold_ecc_q;
    assign rdret_fill_req_id = hold_id_q;
    assign rdret_fill_secc   = hold_secc_q;
    assign rdret_fill_mecc   = hold_mecc_q;
    assign rdret_seq_err     = seq_err_q;
    assign rdret_ovfl_err    = ovfl_err_q;
    assign rdret_tmo_err     = tmo_err_q;

endmodule

// File: tb/tb_dram_l2_rdret_asm.sv
// Bench for the read-return line assembler: directed cases plus random traffic
// against a transaction-level model of partial lines and the fill holding slot.
module tb_dram_l2_rdret_asm;

    localparam int TMO = 20;

    typedef struct packed {
        bit         vld;
        bit [1:0]   ch;
        bit [2:0]   id;
        bit [127:0] d;
        bit [27:0]  e;
        bit         s;
        bit         m;
    } beat_t;

    logic         rclk = 1'b0;
    logic         rst_l = 1'b0;
    logic         vld_r0 = 1'b0;
    logic [1:0]   chunk_r0 = '0;
    logic [2:0]   id_r0 = '0;
    logic [127:0] data_r2 = '0;
    logic [27:0]  ecc_r2 = '0;
    logic         secc_r2 = 1'b0;
    logic         mecc_r2 = 1'b0;
    logic         rdy = 1'b0;
    logic         fill_vld;
    logic [511:0] fill_data;
    logic [111:0] fill_ecc;
    logic [2:0]   fill_id;
    logic         fill_secc;
    logic         fill_mecc;
    logic         seq_err;
    logic         ovfl_err;
    logic         tmo_err;

    always #5 rclk = ~rclk;

    dram_l2_rdret_asm #(.TMO_CYC(TMO)) dut (
        .rclk                    (rclk),
        .rst_l                   (rst_l),
        .dram_sctag_data_vld_r0  (vld_r0),
        .dram_sctag_chunk_id_r0  (chunk_r0),
        .dram_sctag_rd_req_id_r0 (id_r0),
        .dram_scbuf_data_r2      (data_r2),
        .dram_scbuf_ecc_r2       (ecc_r2),
        .dram_sctag_secc_err_r2  (secc_r2),
        .dram_sctag_mecc_err_r2  (mecc_r2),
        .rdret_fill_rdy          (rdy),
        .rdret_fill_vld          (fill_vld),
        .rdret_fill_data         (fill_data),
        .rdret_fill_ecc          (fill_ecc),
        .rdret_fill_req_id       (fill_id),
        .rdret_fill_secc         (fill_secc),
        .rdret_fill_mecc         (fill_mecc),
        .rdret_seq_err           (seq_err),
        .rdret_ovfl_err          (ovfl_err),
        .rdret_tmo_err           (tmo_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: partial line as a chunk list, and one held line.
    bit [127:0] pd [4];
    bit [27:0]  pe [4];
    int         pn, pfirst, pidle;
    bit [2:0]   pid;
    bit         ps, pm;
    bit         hv, hs, hm;
    bit [511:0] hd;
    bit [111:0] he;
    bit [2:0]   hid;
    bit         xseq, xovfl, xtmo;

    beat_t h0, h1;
    bit [2:0] obs_id [$];
    bit       obs_s [$];
    bit       obs_m [$];
    int       obs_seq, obs_ovfl, obs_tmo;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic beat_t mk(input bit v, input bit [1:0] ch, input bit [2:0] id,
                                 input bit s = 1'b0, input bit m = 1'b0);
        beat_t b;
        b.vld = v;
        b.ch  = ch;
        b.id  = id;
        b.d   = {$urandom(), $urandom(), $urandom(), $urandom()};
        b.e   = 28'($urandom());
        b.s   = v ? s : 1'($urandom());
        b.m   = v ? m : 1'($urandom());
        return b;
    endfunction

    function automatic void model_reset();
        pn = 0; pidle = 0; pfirst = 0; pid = '0; ps = 0; pm = 0;
        hv = 0; hs = 0; hm = 0; hd = '0; he = '0; hid = '0;
        xseq = 0; xovfl = 0; xtmo = 0;
    endfunction

    function automatic void model_edge(input beat_t b, input bit r);
        bit done = 1'b0;
        xseq = 0; xovfl = 0; xtmo = 0;
        if (b.vld) begin
            pidle = 0;
            if (pn > 0 && (b.id != pid || int'(b.ch) != (pfirst + pn) % 4)) begin
                xseq = 1;
                pn = 0;
            end
            if (pn == 0) begin
                pfirst = int'(b.ch); pid = b.id; ps = 0; pm = 0;
            end
            pd[b.ch] = b.d;
            pe[b.ch] = b.e;
            ps |= b.s;
            pm |= b.m;
            pn++;
            if (pn == 4) begin
                done = 1'b1;
                pn = 0;
            end
        end else if (pn > 0) begin
            pidle++;
            if (pidle == TMO) begin
                xtmo = 1; pn = 0; pidle = 0;
            end
        end
        if (done) begin
            if (!hv || r) begin
                hv = 1;
                for (int k = 0; k < 4; k++) begin
                    hd[128*k +: 128] = pd[k];
                    he[28*k +: 28]   = pe[k];
                end
                hid = pid; hs = ps; hm = pm;
            end else begin
                xovfl = 1;
            end
        end else if (hv && r) begin
            hv = 0;
        end
    endfunction

    task automatic check_outputs();
        chk("fill_vld", fill_vld, hv);
        if (hv) begin
            chk("fill_data", fill_data, hd);
            chk("fill_ecc", fill_ecc, he);
            chk("fill_id", fill_id, hid);
            chk("fill_secc", fill_secc, hs);
            chk("fill_mecc", fill_mecc, hm);
        end
        chk("seq_err", seq_err, xseq);
        chk("ovfl_err", ovfl_err, xovfl);
        chk("tmo_err", tmo_err, xtmo);
        if (seq_err === 1'b1) obs_seq++;
        if (ovfl_err === 1'b1) obs_ovfl++;
        if (tmo_err === 1'b1) obs_tmo++;
    endtask

    // One clock: nb goes onto r0 now; the beat issued two cycles ago drives r2.
    task automatic step(input beat_t nb, input bit r);
        beat_t cur;
        cur = h1; h1 = h0; h0 = nb;
        vld_r0   = nb.vld;
        chunk_r0 = nb.ch;
        id_r0    = nb.id;
        data_r2  = cur.d;
        ecc_r2   = cur.e;
        secc_r2  = cur.s;
        mecc_r2  = cur.m;
        rdy      = r;
        if (fill_vld === 1'b1 && r) begin
            obs_id.push_back(fill_id);
            obs_s.push_back(fill_secc);
            obs_m.push_back(fill_mecc);
        end
        model_edge(cur, r);
        @(posedge rclk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        rst_l = 1'b0; vld_r0 = 1'b0; rdy = 1'b0;
        h0 = '0; h1 = '0;
        repeat (n) @(posedge rclk);
        #1;
        model_reset();
        check_outputs();
        chk("rst_data", fill_data, 0);
        chk("rst_ecc", fill_ecc, 0);
        chk("rst_id", fill_id, 0);
        rst_l = 1'b1;
    endtask

    task automatic idle(input int n, input bit r = 1'b1);
        repeat (n) step(mk(0, 0, 0), r);
    endtask

    task automatic send(input bit [2:0] id, input bit [1:0] ch, input bit r = 1'b1,
                        input bit s = 1'b0, input bit m = 1'b0);
        step(mk(1, ch, id, s, m), r);
    endtask

    task automatic clr_obs();
        obs_id.delete(); obs_s.delete(); obs_m.delete();
        obs_seq = 0; obs_ovfl = 0; obs_tmo = 0;
    endtask

    function automatic bit rnd_rdy();
        return ($urandom_range(0, 9) < 7);
    endfunction

    bit [2:0] rid;
    bit [1:0] rst_ch;
    int       gap;

    initial begin
        h0 = '0; h1 = '0;
        model_reset();
        clr_obs();
        do_reset(3);

        // In-order line, id 3
        clr_obs();
        for (int c = 0; c < 4; c++) send(3, 2'(c));
        idle(5);
        chk("s1_nfill", obs_id.size(), 1);
        if (obs_id.size() > 0) chk("s1_id", obs_id[0], 3);
        chk("s1_seq", obs_seq, 0);

        // Critical-chunk-first wrap 2,3,0,1, id 1
        clr_obs();
        send(1, 2); send(1, 3); send(1, 0); send(1, 1);
        idle(5);
        chk("s2_nfill", obs_id.size(), 1);
        chk("s2_seq", obs_seq, 0);

        // Error flags on chunks 1 and 3
        clr_obs();
        send(4, 0); send(4, 1, 1, 1, 0); send(4, 2); send(4, 3, 1, 0, 1);
        idle(5);
        chk("s3_nfill", obs_id.size(), 1);
        if (obs_s.size() > 0) chk("s3_secc", obs_s[0], 1);
        if (obs_m.size() > 0) chk("s3_mecc", obs_m[0], 1);

        // Id 5 partial preempted by id 6
        clr_obs();
        send(5, 0); send(5, 1);
        for (int c = 0; c < 4; c++) send(6, 2'(c));
        idle(5);
        chk("s4_seq", obs_seq, 1);
        chk("s4_nfill", obs_id.size(), 1);
        if (obs_id.size() > 0) chk("s4_id", obs_id[0], 6);

        // Held line with fill path stalled, second line overflows
        clr_obs();
        for (int c = 0; c < 4; c++) send(2, 2'(c), 0);
        for (int c = 0; c < 4; c++) send(7, 2'(c), 0);
        idle(6, 0);
        idle(4, 1);
        chk("s5_ovfl", obs_ovfl, 1);
        chk("s5_nfill", obs_id.size(), 1);
        if (obs_id.size() > 0) chk("s5_id", obs_id[0], 2);

        // Partial line times out
        clr_obs();
        send(0, 0); send(0, 1);
        idle(TMO + 5);
        chk("s6_tmo", obs_tmo, 1);
        chk("s6_nfill", obs_id.size(), 0);

        // Gap one short of the timeout still completes
        clr_obs();
        send(3, 0); send(3, 1);
        idle(TMO - 1);
        send(3, 2); send(3, 3);
        idle(5);
        chk("s7_tmo", obs_tmo, 0);
        chk("s7_nfill", obs_id.size(), 1);

        // Reset mid-line discards it silently
        clr_obs();
        send(0, 0); send(0, 1);
        idle(1);
        do_reset(2);
        idle(TMO + 5);
        for (int c = 0; c < 4; c++) send(5, 2'(c));
        idle(5);
        chk("s8_tmo", obs_tmo, 0);
        chk("s8_nfill", obs_id.size(), 1);
        if (obs_id.size() > 0) chk("s8_id", obs_id[0], 5);

        // Random traffic: wrap starts, gaps, occasional faults and stalls
        for (int l = 0; l < 200; l++) begin
            rid    = 3'($urandom());
            rst_ch = 2'($urandom());
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 99) < 3) gap = TMO + $urandom_range(0, 2);
                else if ($urandom_range(0, 3) == 0) gap = $urandom_range(1, 3);
                else gap = 0;
                repeat (gap) step(mk(0, 0, 0), rnd_rdy());
                if ($urandom_range(0, 99) < 5)
                    step(mk(1, 2'($urandom()), 3'($urandom()), 1'($urandom()), 1'($urandom())), rnd_rdy());
                else
                    step(mk(1, rst_ch + 2'(k), rid, $urandom_range(0, 15) == 0,
                            $urandom_range(0, 15) == 0), rnd_rdy());
            end
        end
        idle(TMO + 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dram_l2_rdret_asm.md
# dram_l2_rdret_asm

Read-return line assembler sitting directly downstream of the DRAM-to-L2 repeater column (consumes its `_buf` outputs on the L2 side). Aligns the r0 control strobes with the r2 data beats and collects four 128-bit chunks per request, including critical-chunk-first wrap order, into one 512-bit line with ECC and error summary. Presents the completed line to the L2 fill path over a valid/ready handshake and flags sequence, overflow and timeout faults.

## Interface
Parameters:
- `TMO_CYC`, 63: idle cycles allowed between chunks of a partial line before abort (1..255).

Ports:
- `rclk` in 1: clock.
- `rst_l` in 1: synchronous, active-low reset.
- `dram_sctag_data_vld_r0` in 1: chunk strobe, r0 stage.
- `dram_sctag_chunk_id_r0` in 2: chunk index, r0.
- `dram_sctag_rd_req_id_r0` in 3: request id, r0.
- `dram_scbuf_data_r2` in 128: chunk data, r2 (two cycles after its r0 strobe).
- `dram_scbuf_ecc_r2` in 28: chunk ECC, r2.
- `dram_sctag_secc_err_r2` in 1: single-bit error on this chunk, r2.
- `dram_sctag_mecc_err_r2` in 1: multi-bit error on this chunk, r2.
- `rdret_fill_rdy` in 1: fill path accepts line.
- `rdret_fill_vld` out 1: completed line valid.
- `rdret_fill_data` out 512: chunk k at [128k+127:128k].
- `rdret_fill_ecc` out 112: chunk k ECC at [28k+27:28k].
- `rdret_fill_req_id` out 3: request id of line.
- `rdret_fill_secc` / `rdret_fill_mecc` out 1 each: OR of per-chunk flags.
- `rdret_seq_err` out 1: one-cycle pulse, sequence fault.
- `rdret_ovfl_err` out 1: one-cycle pulse, line dropped.
- `rdret_tmo_err` out 1: one-cycle pulse, partial line timed out.

## Operation
- r0 strobe, chunk id and req id are delayed two registered stages to r2; all assembly decisions are made at r2, when a "beat" is present.
- FSM: IDLE, ASM. Registers: start chunk (2b), beat count (2b), line id (3b), secc/mecc accumulators, idle counter.
- IDLE + beat: capture id, start = chunk id, count = 1, write chunk slot, go ASM.
- ASM + beat: expected chunk = (start + count) mod 4 (wrap-around). Match and same id: write slot, OR in error flags, count++. On the 4th beat, line completes, go IDLE.
- ASM + beat with wrong chunk or different id: pulse `rdret_seq_err`, discard partial line, and treat the offending beat as the first beat of a new line (stay ASM, count = 1).
- Idle counter: cleared on every beat and in IDLE. Increments in ASM without a beat. Reaching `TMO_CYC` pulses `rdret_tmo_err`, discards the line and goes IDLE. A beat in the same cycle wins; no timeout.
- Output holding register (one line): loaded on completion if empty or draining this cycle (`vld & rdy`), giving back-to-back lines with no bubble.
- Completion while holding register is full and not draining: pulse `rdret_ovfl_err`, drop new line, keep held line unchanged.
- `rdret_fill_vld` stays high with data stable until `rdret_fill_rdy` is sampled high.

## Timing
- Reset (`rst_l` low at a `rclk` edge): all outputs 0, FSM IDLE, counters/accumulators 0, r1/r2 delay pipe cleared. Beats in flight are lost, and any partial line is discarded.
- Latency: last chunk's r0 strobe at cycle t, its data at t+2, `rdret_fill_vld` high at t+3.
- Error pulses assert the cycle after the r2 beat or timeout condition that causes them.
- Sustains one line per 4 cycles indefinitely with `rdret_fill_rdy` high.

## Structure
- Shared package `dram_l2_pkg`: chunk width 128, chunk ECC width 28, chunks per line 4, line/ECC widths 512/112, req id width 3, FSM state enum.
- One natural sub-module: `dram_l2_rdret_dly`, the parameterised-depth (2) valid/chunk/id delay pipe aligning r0 control to r2 data.

## Test plan
- Id 3, chunks 0,1,2,3 on consecutive cycles, `rdy`=1 → one-cycle `fill_vld` at t+3, data = {D3,D2,D1,D0}, `req_id`=3, secc=mecc=0.
- Id 1, wrap order 2,3,0,1 → slots filled by chunk index, same data layout as in-order, no `seq_err`.
- Id 4, `secc` on chunk 1 and `mecc` on chunk 3 → `fill_secc`=1 and `fill_mecc`=1.
- Id 5, chunks 0,1, then id 6 chunks 0..3 → `seq_err` pulse on the id-6 chunk-0 beat; only the id-6 line is delivered.
- `rdy`=0, two complete lines (ids 2, 7) → id 2 held, `ovfl_err` pulse at id-7 completion; raise `rdy` → id 2 delivered once, `fill_vld` then drops.
- Chunks 0,1 then silence → `tmo_err` after `TMO_CYC` idle cycles, no fill. Repeat with `rst_l` low mid-line → no pulse, clean next line.
